// File: rtl/bus_host_seq.sv
`default_nettype none
// ============================================================================
// Module   : bus_host_seq
// Purpose  : Ibex-style bus initiator (req/gnt/rvalid). Commands are queued
//            in a FIFO, issued in order under a credit limit, and responses
//            are returned in order through a backpressured response FIFO.
// Options  : BUS_HOST_SEQ_STATS_EN builds the transaction/stall counters;
//            without it n_txn_o and n_stall_o are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module bus_host_seq #(
  parameter int CmdDepth       = 4,
  parameter int MaxOutstanding = 2,
  parameter int AddrWidth      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [3:0]           cmd_be_i,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [31:0]          cmd_wdata_i,
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic                 we_o,
  output logic [3:0]           be_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [31:0]          wdata_o,
  input  logic                 rvalid_i,
  input  logic [31:0]          rdata_i,
  input  logic                 err_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_we_o,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 idle_o,
  output logic                 proto_err_o,
  output logic [31:0]          n_txn_o,
  output logic [31:0]          n_stall_o
);

  localparam int c_cmd_pw = $clog2(CmdDepth);
  localparam int c_cmd_cw = $clog2(CmdDepth + 1);
  localparam int c_out_pw = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int c_out_cw = $clog2(MaxOutstanding + 1);
  localparam int c_cmd_ew = 1 + 4 + AddrWidth + 32;
  localparam int c_rsp_ew = 1 + 32 + 1;

  localparam logic [c_cmd_cw-1:0] c_cmd_full = c_cmd_cw'(CmdDepth);
  localparam logic [c_out_pw-1:0] c_out_last = c_out_pw'(MaxOutstanding - 1);
  localparam logic [c_out_cw:0]   c_out_max  = (c_out_cw + 1)'(MaxOutstanding);

  // Command FIFO storage and control
  logic [c_cmd_ew-1:0] r_cmd_mem [CmdDepth];
  logic [c_cmd_pw-1:0] r_cmd_wptr;
  logic [c_cmd_pw-1:0] r_cmd_rptr;
  logic [c_cmd_cw-1:0] r_cmd_count;
  logic                w_cmd_push;
  logic                w_cmd_pop;
  logic                w_cmd_nonempty;
  logic [c_cmd_ew-1:0] w_cmd_head;

  // In-order tag queue (write flag of each granted request)
  logic                r_tag_mem [MaxOutstanding];
  logic [c_out_pw-1:0] r_tag_wptr;
  logic [c_out_pw-1:0] r_tag_rptr;
  logic [c_out_cw-1:0] r_outstanding;

  // Response FIFO storage and control
  logic [c_rsp_ew-1:0] r_rsp_mem [MaxOutstanding];
  logic [c_out_pw-1:0] r_rsp_wptr;
  logic [c_out_pw-1:0] r_rsp_rptr;
  logic [c_out_cw-1:0] r_rsp_count;
  logic                w_rsp_push;
  logic                w_rsp_pop;
  logic                w_tag_we;
  logic [c_rsp_ew-1:0] w_rsp_head;

  logic [c_out_cw:0]   w_in_use;
  logic                r_proto_err;

  // Ready comes from the registered count, so a full FIFO never takes a push
  // even if the head is being granted in the same cycle.
  assign cmd_ready_o    = (r_cmd_count != c_cmd_full);
  assign w_cmd_push     = cmd_valid_i & cmd_ready_o;
  assign w_cmd_nonempty = (r_cmd_count != '0);
  assign w_cmd_head     = w_cmd_nonempty ? r_cmd_mem[r_cmd_rptr] : '0;
  assign {we_o, be_o, addr_o, wdata_o} = w_cmd_head;

  // Credits count both in-flight requests and buffered responses, which is
  // what keeps the response FIFO from ever overflowing.
  assign w_in_use  = {1'b0, r_outstanding} + {1'b0, r_rsp_count};
  assign req_o     = w_cmd_nonempty & (w_in_use < c_out_max);
  assign w_cmd_pop = req_o & gnt_i;

  assign w_tag_we   = r_tag_mem[r_tag_rptr];
  assign w_rsp_push = rvalid_i & (r_outstanding != '0);
  assign w_rsp_pop  = rsp_valid_o & rsp_ready_i;

  assign w_rsp_head  = r_rsp_mem[r_rsp_rptr];
  assign rsp_valid_o = (r_rsp_count != '0);
  assign rsp_we_o    = rsp_valid_o & w_rsp_head[c_rsp_ew-1];
  assign rsp_rdata_o = rsp_valid_o ? w_rsp_head[32:1] : 32'd0;
  assign rsp_err_o   = rsp_valid_o & w_rsp_head[0];

  assign idle_o      = ~w_cmd_nonempty & ~rsp_valid_o & (r_outstanding == '0);
  assign proto_err_o = r_proto_err;

  // Storage arrays are write-only by data path; control decides validity
  always_ff @(posedge clk_i) begin
    if (w_cmd_push) r_cmd_mem[r_cmd_wptr] <= {cmd_we_i, cmd_be_i, cmd_addr_i, cmd_wdata_i};
    if (w_cmd_pop)  r_tag_mem[r_tag_wptr] <= we_o;
    if (w_rsp_push) r_rsp_mem[r_rsp_wptr] <= {w_tag_we, (w_tag_we ? 32'd0 : rdata_i), err_i};
  end

  // Command FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cmd_wptr  <= '0;
      r_cmd_rptr  <= '0;
      r_cmd_count <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wptr <= r_cmd_wptr + 1'b1;
      if (w_cmd_pop)  r_cmd_rptr <= r_cmd_rptr + 1'b1;
      case ({w_cmd_push, w_cmd_pop})
        2'b10:   r_cmd_count <= r_cmd_count + 1'b1;
        2'b01:   r_cmd_count <= r_cmd_count - 1'b1;
        default: r_cmd_count <= r_cmd_count;
      endcase
    end
  end

  // Tag queue pointers and outstanding count; grant and rvalid together net zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tag_wptr    <= '0;
      r_tag_rptr    <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_cmd_pop)  r_tag_wptr <= (r_tag_wptr == c_out_last) ? '0 : r_tag_wptr + 1'b1;
      if (w_rsp_push) r_tag_rptr <= (r_tag_rptr == c_out_last) ? '0 : r_tag_rptr + 1'b1;
      case ({w_cmd_pop, w_rsp_push})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Response FIFO pointers/occupancy and the sticky protocol error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_wptr  <= '0;
      r_rsp_rptr  <= '0;
      r_rsp_count <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_rsp_push) r_rsp_wptr <= (r_rsp_wptr == c_out_last) ? '0 : r_rsp_wptr + 1'b1;
      if (w_rsp_pop)  r_rsp_rptr <= (r_rsp_rptr == c_out_last) ? '0 : r_rsp_rptr + 1'b1;
      case ({w_rsp_push, w_rsp_pop})
        2'b10:   r_rsp_count <= r_rsp_count + 1'b1;
        2'b01:   r_rsp_count <= r_rsp_count - 1'b1;
        default: r_rsp_count <= r_rsp_count;
      endcase
      if (rvalid_i && (r_outstanding == '0)) r_proto_err <= 1'b1;
    end
  end

`ifdef BUS_HOST_SEQ_STATS_EN
  logic [31:0] r_n_txn;
  logic [31:0] r_n_stall;

  // Saturating transaction and stall counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_n_txn   <= '0;
      r_n_stall <= '0;
    end else begin
      if (w_rsp_push && (r_n_txn != 32'hFFFF_FFFF))          r_n_txn   <= r_n_txn + 32'd1;
      if (req_o && !gnt_i && (r_n_stall != 32'hFFFF_FFFF))   r_n_stall <= r_n_stall + 32'd1;
    end
  end

  assign n_txn_o   = r_n_txn;
  assign n_stall_o = r_n_stall;
`else
  assign n_txn_o   = 32'd0;
  assign n_stall_o = 32'd0;
`endif

endmodule
`default_nettype wire
